vc_demux_2line: RTL and testbench
=================================

VC_DEMUX_2LINE -- requirements
Module: vc_demux_2line

Interface
REQ-001 Parameter: WIDTH, default 32, flit payload width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_data  input  WIDTH  incoming flit payload.
REQ-005 Port: in_vc  input  1  destination lane, sampled on head flits only (0 = lane 0, 1 = lane 1).
REQ-006 Port: in_head  input  1  flit is first of a packet.
REQ-007 Port: in_tail  input  1  flit is last of a packet (head and tail both 1 = single-flit packet).
REQ-008 Port: in_valid  input  1  upstream flit present.
REQ-009 Port: in_ready  output  1  block accepts the flit this cycle.
REQ-010 Port: out0_data / out1_data  output  WIDTH  lane flit payload.
REQ-011 Port: out0_tail / out1_tail  output  1  lane flit tail flag.
REQ-012 Port: out0_valid / out1_valid  output  1  lane flit present.
REQ-013 Port: out0_ready / out1_ready  input  1  downstream accepts lane flit.
REQ-014 Port: err  output  1  one-cycle protocol-error pulse.

Function
REQ-015 The input transfer shall occur when in_valid and in_ready are both 1. Output transfer on lane N shall occur when outN_valid and outN_ready are both 1.
REQ-016 Each lane shall have an independent 2-entry FIFO storing {tail, data}, with a 2-bit occupancy count (0..2) and 1-bit wrapping read/write pointers.
REQ-017 The FSM shall have three states: IDLE (no packet open), LOCK0 (packet open to lane 0) and LOCK1 (packet open to lane 1).
REQ-018 The target lane shall be in_vc in IDLE, lane 0 in LOCK0 and lane 1 in LOCK1.
REQ-019 in_ready shall be combinational: 1 if the target lane FIFO count is less than 2, or if the current flit is to be dropped (REQ-022); otherwise 0. A pop in the same cycle shall not raise in_ready (no pass-through when full).
REQ-020 In IDLE, an accepted head flit shall be written to lane in_vc. The FSM shall go to LOCKin_vc if in_tail = 0, and remain in IDLE if in_tail = 1.
REQ-021 In LOCKn, an accepted flit shall be written to lane n and in_vc shall be ignored. An accepted flit with in_tail = 1 shall return the FSM to IDLE next cycle.
REQ-022 In IDLE, a flit with in_head = 0 and in_valid = 1 shall be accepted (in_ready = 1), discarded and not written to any lane, and err = 1 in the following cycle.
REQ-023 In LOCKn, an accepted flit with in_head = 1 shall pulse err next cycle, shall still be written to lane n, and shall follow the REQ-021 tail rule.
REQ-024 outN_valid shall be 1 exactly when the lane N count is greater than 0. outN_data and outN_tail shall present the entry at the read pointer.
REQ-025 A simultaneous push and pop on the same lane shall leave the count unchanged, and both pointers shall advance. No loss or duplication is allowed at count 0, 1 or 2.
REQ-026 Latency from input acceptance to outN_valid shall be exactly 1 cycle. Flit order within a lane shall be preserved, and the two lanes shall not block each other.
REQ-027 err shall be registered, 1 for exactly one cycle per offending flit, and 0 otherwise.

Reset
REQ-028 While rst = 1 at a rising edge: FSM to IDLE, both counts and pointers to 0, storage cleared to 0, err to 0.
REQ-029 After reset, outN_valid = 0, outN_data = 0, outN_tail = 0 and err = 0. in_ready follows REQ-019 with empty FIFOs (1).
REQ-030 Reset asserted mid-packet shall discard any open packet and all buffered flits. A subsequent non-head flit shall be handled per REQ-022.

Verification
REQ-031 Single-flit packet, head = 1, tail = 1, vc = 1, data 0xDEADBEEF, out1_ready = 1 -> out1_valid = 1 with 0xDEADBEEF and tail = 1 one cycle later; out0_valid stays 0; FSM stays IDLE.
REQ-032 4-flit packet to vc 0 (0x1..0x4), with in_vc toggling on body flits -> all four flits appear on lane 0 in order; lane 1 gets nothing; FSM in IDLE after the tail.
REQ-033 out0_ready = 0, 3-flit packet to lane 0 -> in_ready drops after 2 accepts. Raise out0_ready for one cycle -> in_ready stays 0 in that cycle and returns to 1 the next cycle; the third flit is delivered with no loss.
REQ-034 Lane 0 stalled and full, then a new head to vc 1 after lane 0's tail is accepted -> lane 1 delivers normally while lane 0 stays full.
REQ-035 Body flit (head = 0) in IDLE -> accepted, err pulses for 1 cycle, both outN_valid remain 0.
REQ-036 rst asserted after 2 body flits of an open packet to lane 1 -> next cycle out1_valid = 0, FSM IDLE; the following body flit raises err.

Source files
------------

// File: rtl/vc_demux_2line.sv
// vc_demux_2line
// Demultiplexes a wormhole flit stream onto two virtual-channel lanes.
// The lane is chosen by in_vc on a packet's head flit and stays locked
// until the tail flit has been accepted. Each lane buffers up to two
// {tail, data} entries in its own FIFO, so a stalled lane never blocks
// the other one.
//
// Ports
//   clk, rst               single clock, synchronous active-high reset
//   in_data/in_vc/in_head  incoming flit payload, lane select, head flag
//   in_tail/in_valid       tail flag, flit present
//   in_ready               combinational accept for the current flit
//   outN_data/outN_tail    lane N flit at the FIFO read pointer
//   outN_valid/outN_ready  lane N handshake
//   err                    registered one-cycle protocol-error pulse
module vc_demux_2line #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_vc,
   input  logic             in_head,
   input  logic             in_tail,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_tail,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_tail,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic [WIDTH:0] mem_r [2][2];   // [lane][slot] = {tail, data}
   logic [1:0]     cnt_r [2];
   logic           wr_r  [2];
   logic           rd_r  [2];
   logic           err_r;

   logic           target_s;
   logic           drop_s;
   logic           accept_s;
   logic           err_nxt_s;
   logic [1:0]     push_s;
   logic [1:0]     pop_s;

   // Lane FIFO heads drive the outputs straight from storage registers.
   assign out0_valid = (cnt_r[0] != 2'd0);
   assign out1_valid = (cnt_r[1] != 2'd0);
   assign out0_data  = mem_r[0][rd_r[0]][WIDTH-1:0];
   assign out0_tail  = mem_r[0][rd_r[0]][WIDTH];
   assign out1_data  = mem_r[1][rd_r[1]][WIDTH-1:0];
   assign out1_tail  = mem_r[1][rd_r[1]][WIDTH];
   assign err        = err_r;

   // Target lane, drop decision, input handshake and per-lane push/pop.
   always_comb begin
      target_s  = in_vc;
      push_s    = 2'b00;
      pop_s     = 2'b00;
      case (state_r)
         IDLE:    target_s = in_vc;
         LOCK0:   target_s = 1'b0;
         LOCK1:   target_s = 1'b1;
         default: target_s = in_vc;
      endcase
      // A body flit with no open packet is swallowed rather than stalled.
      drop_s = (state_r == IDLE) && !in_head;
      // Ready looks at the count before any pop: no pass-through when full.
      in_ready = drop_s || (cnt_r[target_s] < 2'd2);
      accept_s = in_valid && in_ready;
      if (accept_s && !drop_s) begin
         push_s[target_s] = 1'b1;
      end else begin
         push_s = 2'b00;
      end
      pop_s[0]  = out0_valid && out0_ready;
      pop_s[1]  = out1_valid && out1_ready;
      err_nxt_s = accept_s && (drop_s || ((state_r != IDLE) && in_head));
   end

   // Packet-lock next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s && !drop_s && !in_tail) begin
               state_nxt_s = in_vc ? LOCK1 : LOCK0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOCK0, LOCK1: begin
            if (accept_s && in_tail) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register, error pulse and the two lane FIFOs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         err_r   <= 1'b0;
         for (int l = 0; l < 2; l++) begin
            cnt_r[l]    <= 2'd0;
            wr_r[l]     <= 1'b0;
            rd_r[l]     <= 1'b0;
            mem_r[l][0] <= '0;
            mem_r[l][1] <= '0;
         end
      end else begin
         state_r <= state_nxt_s;
         err_r   <= err_nxt_s;
         for (int l = 0; l < 2; l++) begin
            if (push_s[l]) begin
               mem_r[l][wr_r[l]] <= {in_tail, in_data};
               wr_r[l]           <= ~wr_r[l];
            end
            if (pop_s[l]) begin
               rd_r[l] <= ~rd_r[l];
            end
            case ({push_s[l], pop_s[l]})
               2'b10:   cnt_r[l] <= cnt_r[l] + 2'd1;
               2'b01:   cnt_r[l] <= cnt_r[l] - 2'd1;
               default: cnt_r[l] <= cnt_r[l];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vc_demux_2line.sv
// Testbench for vc_demux_2line: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based packet model.
module tb_vc_demux_2line;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_vc, in_head, in_tail, in_valid, in_ready;
   logic [WIDTH-1:0] out0_data, out1_data;
   logic             out0_tail, out1_tail, out0_valid, out1_valid;
   logic             out0_ready, out1_ready, err;

   int checks = 0;
   int errors = 0;

   // Reference model: per-lane queues of {tail, data}, open lane (-1 none).
   logic [WIDTH:0] q0[$];
   logic [WIDTH:0] q1[$];
   int             open_lane = -1;
   logic           exp_err = 1'b0;

   vc_demux_2line #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_vc(in_vc), .in_head(in_head), .in_tail(in_tail),
      .in_valid(in_valid), .in_ready(in_ready),
      .out0_data(out0_data), .out0_tail(out0_tail), .out0_valid(out0_valid),
      .out0_ready(out0_ready),
      .out1_data(out1_data), .out1_tail(out1_tail), .out1_valid(out1_valid),
      .out1_ready(out1_ready),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive, check against the model, clock, update model.
   task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] d,
                       input bit vc, input bit h, input bit t,
                       input bit r0, input bit r1);
      int  tgt;
      bit  drop, rdy, acc;
      rst = r; in_valid = v; in_data = d; in_vc = vc; in_head = h; in_tail = t;
      out0_ready = r0; out1_ready = r1;
      #1;
      tgt  = (open_lane < 0) ? int'(vc) : open_lane;
      drop = (open_lane < 0) && !h;
      rdy  = drop || ((tgt == 0) ? (q0.size() < 2) : (q1.size() < 2));
      check("in_ready", {63'd0, in_ready}, {63'd0, rdy});
      check("out0_valid", {63'd0, out0_valid}, {63'd0, q0.size() > 0});
      check("out1_valid", {63'd0, out1_valid}, {63'd0, q1.size() > 0});
      if (q0.size() > 0) check("out0_flit", {31'd0, out0_tail, out0_data}, {31'd0, q0[0]});
      if (q1.size() > 0) check("out1_flit", {31'd0, out1_tail, out1_data}, {31'd0, q1[0]});
      check("err", {63'd0, err}, {63'd0, exp_err});
      @(posedge clk);
      if (r) begin
         q0.delete(); q1.delete(); open_lane = -1; exp_err = 1'b0;
      end else begin
         if (r0 && q0.size() > 0) void'(q0.pop_front());
         if (r1 && q1.size() > 0) void'(q1.pop_front());
         acc     = v && rdy;
         exp_err = acc && (drop || (open_lane >= 0 && h));
         if (acc && !drop) begin
            if (tgt == 0) q0.push_back({t, d}); else q1.push_back({t, d});
            if (t) open_lane = -1;
            else   open_lane = tgt;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit r0, input bit r1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, r0, r1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_vc = 1'b0; in_head = 1'b0;
      in_tail = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
      @(negedge clk);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0; #1;
      check("rst_out0_data", {32'd0, out0_data}, 64'd0);
      check("rst_out1_data", {32'd0, out1_data}, 64'd0);
      check("rst_tails", {62'd0, out0_tail, out1_tail}, 64'd0);
      check("rst_valids", {62'd0, out0_valid, out1_valid}, 64'd0);
      check("rst_err", {63'd0, err}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Single-flit packet to lane 1.
      step(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("single_v1", {63'd0, out1_valid}, 64'd1);
      check("single_d1", {32'd0, out1_data}, 64'hDEADBEEF);
      check("single_t1", {63'd0, out1_tail}, 64'd1);
      check("single_v0", {63'd0, out0_valid}, 64'd0);
      idle(1'b1, 1'b1);

      // 4-flit packet to lane 0 with in_vc toggling on body flits.
      step(1'b0, 1'b1, 32'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      check("pkt4_last", {31'd0, out0_tail, out0_data}, {31'd0, 1'b1, 32'h4});
      check("pkt4_lane1", {63'd0, out1_valid}, 64'd0);
      idle(1'b1, 1'b1);

      // Back-pressure: lane 0 fills after two accepts, pop does not pass through.
      step(1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("bp_full_head", {32'd0, out0_data}, 64'hB);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);

      // Lane 0 stalled and full; lane 1 still delivers.
      step(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      check("indep_v1", {32'd0, out1_data}, 64'h20);
      check("indep_v0", {63'd0, out0_valid}, 64'd1);
      idle(1'b0, 1'b1);
      idle(1'b1, 1'b1);
      idle(1'b1, 1'b1);

      // Body flit with no open packet.
      step(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("drop_err", {63'd0, err}, 64'd1);
      check("drop_valids", {62'd0, out0_valid, out1_valid}, 64'd0);
      idle(1'b1, 1'b1);
      check("drop_err_clear", {63'd0, err}, 64'd0);

      // Reset in the middle of a lane-1 packet.
      step(1'b0, 1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0; #1;
      check("mid_rst_v1", {63'd0, out1_valid}, 64'd0);
      step(1'b0, 1'b1, 32'h32, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("mid_rst_err", {63'd0, err}, 64'd1);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom,
              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
